// File: rtl/vreg_read_sched.sv
// Banked vreg/mask register-file read scheduler: maps operand sources to banks,
// resolves bank conflicts over issue rounds and returns per-port data strobes.
module vreg_read_sched #(
  parameter int READ_PORTS = 4,
  parameter int MASK_PORTS = 2,
  parameter int VBANKS     = 4,
  parameter int MBANKS     = 2,
  parameter int VIDX_W     = 6,
  parameter int MIDX_W     = 4,
  parameter int VREG_W     = 512,
  parameter int VMASK_W    = 32
) (
  input  logic                                         CLK,
  input  logic                                         nRST,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [READ_PORTS*VIDX_W-1:0]                 req_vidx,
  input  logic [READ_PORTS-1:0]                        req_ven,
  input  logic [MASK_PORTS*MIDX_W-1:0]                 req_midx,
  input  logic [MASK_PORTS-1:0]                        req_men,
  input  logic                                         flush,
  output logic [VBANKS-1:0]                            vbank_ren,
  output logic [VBANKS*(VIDX_W-$clog2(VBANKS))-1:0]    vbank_raddr,
  input  logic [VBANKS*VREG_W-1:0]                     vbank_rdata,
  output logic [MBANKS-1:0]                            mbank_ren,
  output logic [MBANKS*(MIDX_W-$clog2(MBANKS))-1:0]    mbank_raddr,
  input  logic [MBANKS*VMASK_W-1:0]                    mbank_rdata,
  output logic [READ_PORTS-1:0]                        dvalid,
  output logic [READ_PORTS*VREG_W-1:0]                 vreg,
  output logic [MASK_PORTS-1:0]                        mvalid,
  output logic [MASK_PORTS*VMASK_W-1:0]                vmask,
  output logic                                         no_conflict,
  output logic [1:0]                                   dbg_state
);

  localparam int VB_W   = $clog2(VBANKS);
  localparam int VROW_W = VIDX_W - VB_W;
  localparam int MB_W   = $clog2(MBANKS);
  localparam int MROW_W = MIDX_W - MB_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1} state_t;

  // Handshake: a request transfers on a cycle where req_valid & req_ready are
  // both high and flush is low; req_valid may be held until that happens.
  state_t                        r_state;
  logic                          r_live;
  logic                          r_first;
  logic [READ_PORTS*VIDX_W-1:0]  r_vidx;
  logic [READ_PORTS-1:0]         r_ven;
  logic [READ_PORTS-1:0]         r_vpend;
  logic [MASK_PORTS*MIDX_W-1:0]  r_midx;
  logic [MASK_PORTS-1:0]         r_men;
  logic [MASK_PORTS-1:0]         r_mpend;
  logic [READ_PORTS-1:0]         r_dvalid;
  logic [READ_PORTS-1:0]         r_dused;
  logic [VB_W-1:0]               r_dsel [READ_PORTS];
  logic [MASK_PORTS-1:0]         r_mvalid;
  logic [MASK_PORTS-1:0]         r_mused;
  logic [MB_W-1:0]               r_msel [MASK_PORTS];
  logic                          r_nc;

  logic                          w_issue;
  logic                          w_last;
  logic                          w_accept;
  logic [READ_PORTS-1:0]         w_vblk;
  logic [READ_PORTS-1:0]         w_vgnt;
  logic [MASK_PORTS-1:0]         w_mblk;
  logic [MASK_PORTS-1:0]         w_mgnt;

  assign w_issue   = (r_state == S_ISSUE);
  assign w_last    = ((r_vpend & ~w_vgnt) == '0) && ((r_mpend & ~w_mgnt) == '0);
  assign req_ready = r_live & (~w_issue | w_last);
  assign w_accept  = req_valid & req_ready & ~flush;

  // A port is blocked only by a lower pending port on its bank reading a
  // different row; equal indices ride along on the winner's read.
  always_comb begin
    w_vblk      = '0;
    w_vgnt      = '0;
    vbank_ren   = '0;
    vbank_raddr = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      for (int q = 0; q < READ_PORTS; q++) begin
        if (q < p && r_vpend[q] &&
            r_vidx[q*VIDX_W +: VB_W] == r_vidx[p*VIDX_W +: VB_W] &&
            r_vidx[q*VIDX_W +: VIDX_W] != r_vidx[p*VIDX_W +: VIDX_W])
          w_vblk[p] = 1'b1;
      end
      w_vgnt[p] = w_issue & r_vpend[p] & ~w_vblk[p];
      if (w_vgnt[p]) begin
        vbank_ren[r_vidx[p*VIDX_W +: VB_W]] = 1'b1;
        vbank_raddr[int'(r_vidx[p*VIDX_W +: VB_W])*VROW_W +: VROW_W] =
          r_vidx[p*VIDX_W+VB_W +: VROW_W];
      end
    end
  end

  always_comb begin
    w_mblk      = '0;
    w_mgnt      = '0;
    mbank_ren   = '0;
    mbank_raddr = '0;
    for (int p = 0; p < MASK_PORTS; p++) begin
      for (int q = 0; q < MASK_PORTS; q++) begin
        if (q < p && r_mpend[q] &&
            r_midx[q*MIDX_W +: MB_W] == r_midx[p*MIDX_W +: MB_W] &&
            r_midx[q*MIDX_W +: MIDX_W] != r_midx[p*MIDX_W +: MIDX_W])
          w_mblk[p] = 1'b1;
      end
      w_mgnt[p] = w_issue & r_mpend[p] & ~w_mblk[p];
      if (w_mgnt[p]) begin
        mbank_ren[r_midx[p*MIDX_W +: MB_W]] = 1'b1;
        mbank_raddr[int'(r_midx[p*MIDX_W +: MB_W])*MROW_W +: MROW_W] =
          r_midx[p*MIDX_W+MB_W +: MROW_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_live   <= 1'b0;
      r_first  <= 1'b0;
      r_vidx   <= '0;
      r_ven    <= '0;
      r_vpend  <= '0;
      r_midx   <= '0;
      r_men    <= '0;
      r_mpend  <= '0;
      r_dvalid <= '0;
      r_dused  <= '0;
      r_mvalid <= '0;
      r_mused  <= '0;
      r_nc     <= 1'b0;
      for (int p = 0; p < READ_PORTS; p++) r_dsel[p] <= '0;
      for (int p = 0; p < MASK_PORTS; p++) r_msel[p] <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (flush) begin
            r_vpend <= '0;
            r_mpend <= '0;
            r_state <= S_IDLE;
          end else begin
            r_vpend <= r_vpend & ~w_vgnt;
            r_mpend <= r_mpend & ~w_mgnt;
            r_first <= 1'b0;
            if (w_last && !w_accept) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_accept) begin
        r_vidx  <= req_vidx;
        r_ven   <= req_ven;
        r_vpend <= req_ven;
        r_midx  <= req_midx;
        r_men   <= req_men;
        r_mpend <= req_men;
        r_first <= 1'b1;
      end
      // Unused ports report once, in the op's first response cycle.
      r_dvalid <= flush ? '0 : (w_vgnt | ((w_issue && r_first) ? ~r_ven : '0));
      r_mvalid <= flush ? '0 : (w_mgnt | ((w_issue && r_first) ? ~r_men : '0));
      r_dused  <= flush ? '0 : w_vgnt;
      r_mused  <= flush ? '0 : w_mgnt;
      r_nc     <= w_issue & ~flush & r_first & w_last;
      for (int p = 0; p < READ_PORTS; p++) r_dsel[p] <= r_vidx[p*VIDX_W +: VB_W];
      for (int p = 0; p < MASK_PORTS; p++) r_msel[p] <= r_midx[p*MIDX_W +: MB_W];
    end
  end

  always_comb begin
    vreg  = '0;
    vmask = '0;
    for (int p = 0; p < READ_PORTS; p++)
      if (r_dused[p]) vreg[p*VREG_W +: VREG_W] = vbank_rdata[int'(r_dsel[p])*VREG_W +: VREG_W];
    for (int p = 0; p < MASK_PORTS; p++)
      if (r_mused[p]) vmask[p*VMASK_W +: VMASK_W] = mbank_rdata[int'(r_msel[p])*VMASK_W +: VMASK_W];
  end

  assign dvalid      = r_dvalid;
  assign mvalid      = r_mvalid;
  assign no_conflict = r_nc;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_vreg_read_sched.sv
// Bench for vreg_read_sched: bank RAM model, request driver, round-by-round
// reference scheduler feeding an expected-response queue, and a cycle monitor.
module tb_vreg_read_sched;

  localparam int EXP_W = 32 + 4 + 2 + 1 + 2048 + 64;

  logic          CLK;
  logic          nRST;
  logic          req_valid;
  logic          req_ready;
  logic [23:0]   req_vidx;
  logic [3:0]    req_ven;
  logic [7:0]    req_midx;
  logic [1:0]    req_men;
  logic          flush;
  logic [3:0]    vbank_ren;
  logic [15:0]   vbank_raddr;
  logic [2047:0] vbank_rdata;
  logic [1:0]    mbank_ren;
  logic [5:0]    mbank_raddr;
  logic [63:0]   mbank_rdata;
  logic [3:0]    dvalid;
  logic [2047:0] vreg;
  logic [1:0]    mvalid;
  logic [63:0]   vmask;
  logic          no_conflict;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [EXP_W-1:0] exp_q[$];

  vreg_read_sched dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .req_vidx(req_vidx), .req_ven(req_ven), .req_midx(req_midx), .req_men(req_men),
    .flush(flush), .vbank_ren(vbank_ren), .vbank_raddr(vbank_raddr),
    .vbank_rdata(vbank_rdata), .mbank_ren(mbank_ren), .mbank_raddr(mbank_raddr),
    .mbank_rdata(mbank_rdata), .dvalid(dvalid), .vreg(vreg), .mvalid(mvalid),
    .vmask(vmask), .no_conflict(no_conflict), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] vdat(input logic [1:0] b, input logic [3:0] row);
    logic [31:0] word;
    word = {6'b100000, b, 4'h0, row, 16'hC3A5};
    return {16{word}};
  endfunction

  function automatic logic [31:0] mdat(input logic b, input logic [2:0] row);
    return {7'b0100000, b, 5'b00000, row, 16'h9E37};
  endfunction

  // Bank RAMs: data one cycle after ren, garbage otherwise.
  always @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      vbank_rdata[b*512 +: 512] <= vbank_ren[b] ? vdat(2'(b), vbank_raddr[b*4 +: 4]) : {16{$urandom}};
    for (int b = 0; b < 2; b++)
      mbank_rdata[b*32 +: 32] <= mbank_ren[b] ? mdat(1'(b), mbank_raddr[b*3 +: 3]) : $urandom;
  end

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: each round, per bank the lowest pending port wins and any
  // pending port with the very same index shares the read.
  task automatic model_push(input logic [23:0] vi, input logic [3:0] ve,
                            input logic [7:0] mi, input logic [1:0] me, input int acc);
    logic [3:0]    vp, vg;
    logic [1:0]    mp, mg;
    logic [3:0]    dv_a [4];
    logic [1:0]    mv_a [4];
    logic [2047:0] vd_a [4];
    logic [63:0]   md_a [4];
    logic [EXP_W-1:0] e;
    int r, w;
    vp = ve; mp = me; r = 0;
    while ((r == 0 || vp != 0 || mp != 0) && r < 4) begin
      vg = '0; mg = '0;
      for (int b = 0; b < 4; b++) begin
        w = -1;
        for (int p = 0; p < 4; p++) if (w < 0 && vp[p] && vi[p*6 +: 2] == 2'(b)) w = p;
        if (w >= 0) for (int p = 0; p < 4; p++) if (vp[p] && vi[p*6 +: 6] == vi[w*6 +: 6]) vg[p] = 1'b1;
      end
      for (int b = 0; b < 2; b++) begin
        w = -1;
        for (int p = 0; p < 2; p++) if (w < 0 && mp[p] && mi[p*4] == 1'(b)) w = p;
        if (w >= 0) for (int p = 0; p < 2; p++) if (mp[p] && mi[p*4 +: 4] == mi[w*4 +: 4]) mg[p] = 1'b1;
      end
      vp = vp & ~vg;
      mp = mp & ~mg;
      dv_a[r] = vg | ((r == 0) ? ~ve : 4'b0000);
      mv_a[r] = mg | ((r == 0) ? ~me : 2'b00);
      vd_a[r] = '0;
      md_a[r] = '0;
      for (int p = 0; p < 4; p++) if (vg[p]) vd_a[r][p*512 +: 512] = vdat(vi[p*6 +: 2], vi[p*6+2 +: 4]);
      for (int p = 0; p < 2; p++) if (mg[p]) md_a[r][p*32 +: 32] = mdat(mi[p*4], mi[p*4+1 +: 3]);
      r++;
    end
    for (int k = 0; k < r; k++) begin
      e = {32'(acc + 2 + k), dv_a[k], mv_a[k], (r == 1 && k == 0), vd_a[k], md_a[k]};
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every cycle either matches the queued response or is silent.
  logic [EXP_W-1:0] mon_e;
  logic [3:0]       mon_dv;
  logic [1:0]       mon_mv;
  logic             mon_nc;
  logic [2047:0]    mon_vd;
  logic [63:0]      mon_md;

  always @(negedge CLK) begin
    if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) == cyc) begin
      mon_e  = exp_q.pop_front();
      mon_md = mon_e[63:0];
      mon_vd = mon_e[2111:64];
      mon_nc = mon_e[2112];
      mon_mv = mon_e[2114:2113];
      mon_dv = mon_e[2118:2115];
      check("dvalid", dvalid, mon_dv);
      check("mvalid", mvalid, mon_mv);
      check("no_conflict", no_conflict, mon_nc);
      for (int p = 0; p < 4; p++) if (mon_dv[p]) check("vreg_data", vreg[p*512 +: 512], mon_vd[p*512 +: 512]);
      for (int p = 0; p < 2; p++) if (mon_mv[p]) check("vmask_data", vmask[p*32 +: 32], mon_md[p*32 +: 32]);
    end else begin
      check("idle_valids", {dvalid, mvalid, no_conflict}, '0);
    end
  end

  // driver tasks: entered and left at a falling edge
  task automatic send(input logic [23:0] vi, input logic [3:0] ve,
                      input logic [7:0] mi, input logic [1:0] me, input bit push);
    int waited;
    waited = 0;
    req_valid = 1'b1; req_vidx = vi; req_ven = ve; req_midx = mi; req_men = me;
    #1;
    while (!req_ready && waited < 50) begin
      @(negedge CLK); #1; waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1'b1);
    end else if (push) begin
      model_push(vi, ve, mi, me, cyc);
    end
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [23:0] pack_v(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  initial begin
    req_valid = 0; req_vidx = '0; req_ven = '0; req_midx = '0; req_men = '0; flush = 0;
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    check("rst_ready", req_ready, 1'b0);
    check("rst_valids", {dvalid, mvalid, no_conflict}, '0);
    check("rst_ren", {vbank_ren, mbank_ren}, '0);
    check("rst_state", dbg_state, 2'd0);
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK); @(negedge CLK);
    check("ready_after_rst", req_ready, 1'b1);

    // conflict-free, all enabled
    send(pack_v(0, 1, 2, 3), 4'b1111, {4'd1, 4'd0}, 2'b11, 1'b1);
    #1;
    check("s1_vren", vbank_ren, 4'b1111);
    check("s1_mren", mbank_ren, 2'b11);
    check("s1_vraddr", vbank_raddr, 16'h0000);
    idle(4);

    // three-way conflict on bank 0
    send(pack_v(0, 4, 8, 1), 4'b1111, {4'd1, 4'd0}, 2'b11, 1'b1);
    #1 check("s2_ready_t1", req_ready, 1'b0);
    @(negedge CLK); #1 check("s2_ready_t2", req_ready, 1'b0);
    @(negedge CLK); #1 check("s2_ready_t3", req_ready, 1'b1);
    @(negedge CLK);
    idle(3);

    // shared read of index 5
    send(pack_v(5, 5, 5, 5), 4'b1111, {4'd3, 4'd3}, 2'b11, 1'b1);
    #1;
    check("s3_vren", vbank_ren, 4'b0010);
    check("s3_vraddr_b1", vbank_raddr[4 +: 4], 4'd1);
    idle(4);

    // back-to-back conflict-free
    for (int i = 0; i < 6; i++) begin
      int rw;
      rw = $urandom_range(0, 15);
      #1 check("b2b_ready", req_ready, 1'b1);
      send(pack_v(rw*4 + 2, ((rw+1)%16)*4 + 0, rw*4 + 3, ((rw+5)%16)*4 + 1), 4'b1111,
           {4'(($urandom_range(0, 7))*2 + 1), 4'(($urandom_range(0, 7))*2)}, 2'b11, 1'b1);
    end
    idle(4);

    // partial enables, then all disabled
    send(pack_v(7, 9, 3, 6), 4'b0010, 8'h5A, 2'b00, 1'b1);
    idle(3);
    send(pack_v(1, 2, 3, 4), 4'b0000, 8'h21, 2'b00, 1'b1);
    #1 check("zero_en_vren", {vbank_ren, mbank_ren}, '0);
    idle(3);

    // flush during first round of a 3-round op
    send(pack_v(0, 4, 8, 1), 4'b1111, {4'd1, 4'd0}, 2'b11, 1'b0);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    #1;
    check("flush_state", dbg_state, 2'd0);
    check("flush_ren", {vbank_ren, mbank_ren}, '0);
    idle(4);

    // flush coincident with accept discards the request
    req_valid = 1'b1; req_vidx = pack_v(0, 4, 8, 12); req_ven = 4'b1111; flush = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0; flush = 1'b0;
    #1 check("flush_accept_state", dbg_state, 2'd0);
    idle(3);

    // reset mid-op
    send(pack_v(0, 4, 8, 1), 4'b1111, {4'd1, 4'd0}, 2'b11, 1'b1);
    @(negedge CLK);
    #2 nRST = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valids", {dvalid, mvalid, no_conflict}, '0);
    check("mid_rst_ren", {vbank_ren, mbank_ren}, '0);
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_data", {|vreg, |vmask}, 2'b00);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK); @(negedge CLK);
    check("mid_rst_ready_after", req_ready, 1'b1);
    send(pack_v(0, 1, 2, 3), 4'b1111, {4'd1, 4'd0}, 2'b11, 1'b1);
    #1 check("post_rst_vren", vbank_ren, 4'b1111);
    idle(4);

    // random traffic
    for (int i = 0; i < 25; i++) begin
      send(24'($urandom), 4'($urandom), 8'($urandom), 2'($urandom), 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(10);
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
